// File: rtl/k423_dmem_resp.sv
// Tightly-coupled data memory responder: word SRAM with byte-lane writes, fixed-latency
// in-order responses through a credit-bounded circular response buffer.
module k423_dmem_resp #(
    parameter int ADDR_W    = 32,
    parameter int XLEN      = 32,
    parameter int DEPTH_W   = 10,
    parameter int LATENCY   = 1,
    parameter int OUT_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              mem_req_vld_i,
    output logic              mem_req_rdy_o,
    input  logic [XLEN/8-1:0] mem_req_wen_i,
    input  logic [ADDR_W-1:0] mem_req_addr_i,
    input  logic [XLEN-1:0]   mem_req_wdata_i,
    output logic              mem_rsp_vld_o,
    input  logic              mem_rsp_rdy_i,
    output logic [XLEN-1:0]   mem_rsp_rdata_o,
    output logic              mem_rsp_err_o
);
    localparam int NB     = XLEN / 8;
    localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
    localparam int PIPE_N = (LATENCY > 1) ? LATENCY - 1 : 1;

    logic [XLEN-1:0]    mem_q [2**DEPTH_W];
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept, pop, is_wr, oor;
    logic [DEPTH_W-1:0] idx;
    logic [XLEN-1:0]    acc_rdata;
    logic               unused_addr_lsb;

    logic               push_vld, push_err;
    logic [XLEN-1:0]    push_data;

    logic [XLEN-1:0]      buf_data_q [OUT_DEPTH];
    logic [OUT_DEPTH-1:0] buf_err_q;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     occ_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready depends only on the registered credit count, never on this cycle's handshakes.
    assign mem_req_rdy_o   = (cnt_q < CNT_W'(OUT_DEPTH));
    assign accept          = mem_req_vld_i & mem_req_rdy_o;
    assign pop             = mem_rsp_vld_o & mem_rsp_rdy_i;
    assign idx             = mem_req_addr_i[DEPTH_W+1:2];
    assign is_wr           = |mem_req_wen_i;
    assign unused_addr_lsb = ^mem_req_addr_i[1:0];

    generate
        if (ADDR_W > DEPTH_W + 2) begin : g_range
            assign oor = |mem_req_addr_i[ADDR_W-1:DEPTH_W+2];
        end else begin : g_norange
            assign oor = 1'b0;
        end
    endgenerate

    assign acc_rdata = (!is_wr && !oor) ? mem_q[idx] : '0;

    // The array is not reset; accepted writes survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && accept && is_wr && !oor) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_req_wen_i[i]) begin
                    mem_q[idx][8*i +: 8] <= mem_req_wdata_i[8*i +: 8];
                end
            end
        end
    end

    generate
        if (LATENCY > 1) begin : g_pipe
            logic [PIPE_N-1:0] vld_q;
            logic [PIPE_N-1:0] err_q;
            logic [XLEN-1:0]   data_q [PIPE_N];

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= accept;
                    for (int s = 1; s < PIPE_N; s++) vld_q[s] <= vld_q[s-1];
                end
            end

            always_ff @(posedge clk_i) begin
                data_q[0] <= acc_rdata;
                err_q[0]  <= oor;
                for (int s = 1; s < PIPE_N; s++) begin
                    data_q[s] <= data_q[s-1];
                    err_q[s]  <= err_q[s-1];
                end
            end

            assign push_vld  = vld_q[PIPE_N-1];
            assign push_data = data_q[PIPE_N-1];
            assign push_err  = err_q[PIPE_N-1];
        end else begin : g_nopipe
            assign push_vld  = accept;
            assign push_data = acc_rdata;
            assign push_err  = oor;
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(pop);
    end

    // Credits cover in-flight plus buffered entries, so the buffer cannot overflow.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            occ_q <= occ_q + CNT_W'(push_vld) - CNT_W'(pop);
            if (push_vld) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)      rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_vld) begin
            buf_data_q[wr_ptr_q] <= push_data;
            buf_err_q[wr_ptr_q]  <= push_err;
        end
    end

    assign mem_rsp_vld_o   = (occ_q != '0);
    assign mem_rsp_rdata_o = mem_rsp_vld_o ? buf_data_q[rd_ptr_q] : '0;
    assign mem_rsp_err_o   = mem_rsp_vld_o & buf_err_q[rd_ptr_q];

endmodule

// File: tb/tb_k423_dmem_resp.sv
// Bench for k423_dmem_resp: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_k423_dmem_resp;
    localparam int LAT = 1;
    localparam int OD  = 2;
    localparam int DW  = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_vld, req_rdy, rsp_vld, rsp_rdy, rsp_err;
    logic [3:0]  wen;
    logic [31:0] addr, wdata, rsp_rdata;

    typedef struct {logic [31:0] data; logic err; int avail;} ent_t;
    typedef struct {logic [31:0] data; logic err; int t;} rec_t;

    ent_t        q[$];
    rec_t        got[$];
    logic [31:0] mm [int];
    int          cyc = 0, tick = 0, ntot = 0, npass = 0;
    ent_t        e;
    bit          pop_m, acc_m, ev;
    int          w;

    k423_dmem_resp #(.ADDR_W(32), .XLEN(32), .DEPTH_W(DW), .LATENCY(LAT), .OUT_DEPTH(OD)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .mem_req_vld_i(req_vld), .mem_req_rdy_o(req_rdy), .mem_req_wen_i(wen),
        .mem_req_addr_i(addr), .mem_req_wdata_i(wdata),
        .mem_rsp_vld_o(rsp_vld), .mem_rsp_rdy_i(rsp_rdy),
        .mem_rsp_rdata_o(rsp_rdata), .mem_rsp_err_o(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tick++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: accepted requests enter a queue and become visible LAT-1 edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            pop_m = (q.size() > 0) && (q[0].avail <= cyc) && rsp_rdy;
            acc_m = req_vld && (q.size() < OD);
            cyc++;
            if (pop_m) void'(q.pop_front());
            if (acc_m) begin
                w = int'(addr[11:2]);
                e.avail = cyc + LAT - 1;
                e.data  = 32'h0;
                e.err   = (addr[31:12] != 20'h0);
                if (!e.err) begin
                    if (!mm.exists(w)) mm[w] = 32'h0;
                    if (wen == 4'h0) e.data = mm[w];
                    for (int l = 0; l < 4; l++)
                        if (wen[l]) mm[w][8*l +: 8] = wdata[8*l +: 8];
                end
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rsp_vld", rsp_vld, 1'b0);
            chk("rst_rsp_rdata", rsp_rdata, 32'h0);
            chk("rst_rsp_err", rsp_err, 1'b0);
        end else begin
            ev = (q.size() > 0) && (q[0].avail <= cyc);
            chk("req_rdy", req_rdy, q.size() < OD);
            chk("rsp_vld", rsp_vld, ev);
            if (ev) begin
                chk("rsp_rdata", rsp_rdata, q[0].data);
                chk("rsp_err", rsp_err, q[0].err);
            end
            if (rsp_vld && rsp_rdy) got.push_back('{rsp_rdata, rsp_err, tick});
        end
    end

    task automatic send(input logic [3:0] w_, input logic [31:0] a, input logic [31:0] d);
        bit ok;
        ok = 0;
        req_vld = 1'b1; wen = w_; addr = a; wdata = d;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (req_rdy) ok = 1;
            @(posedge clk); #1;
        end
        req_vld = 1'b0;
        if (!ok) begin
            ntot++;
            $display("FAIL send_timeout: addr %0h not accepted", a);
        end
    endtask

    task automatic wait_got(input int n, input string nm);
        for (int i = 0; i < 200 && got.size() < n; i++) @(negedge clk);
        if (got.size() < n) begin
            ntot++;
            $display("FAIL %s: only %0d responses, need %0d", nm, got.size(), n);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t0, n_at;
        rst_n = 1'b0; req_vld = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0; rsp_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t1_rdy", req_rdy, 1'b1);
        chk("t1_vld", rsp_vld, 1'b0);
        chk("t1_rdata", rsp_rdata, 32'h0);
        chk("t1_err", rsp_err, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) send(4'hF, 32'(i * 4), 32'hC0DE_0000 | 32'(i));
        idle(3);

        // Full write then read-after-write
        base = got.size();
        send(4'hF, 32'h40, 32'hDEADBEEF);
        send(4'h0, 32'h40, 32'h0);
        @(negedge clk);
        chk("t2_rd_vld", rsp_vld, 1'b1);
        chk("t2_rd_data", rsp_rdata, 32'hDEADBEEF);
        wait_got(base + 2, "t2_wait");
        chk("t2_wr_rdata", got[base].data, 32'h0);
        chk("t2_wr_err", got[base].err, 1'b0);
        chk("t2_rd_rdata", got[base+1].data, 32'hDEADBEEF);
        idle(2);

        // Byte-lane write
        base = got.size();
        send(4'h2, 32'h40, 32'h0000A500);
        send(4'h0, 32'h40, 32'h0);
        wait_got(base + 2, "t3_wait");
        chk("t3_lane_rdata", got[base+1].data, 32'hDEADA5EF);
        idle(2);

        // Backpressure with a held third request
        rsp_rdy = 1'b0;
        base = got.size();
        send(4'h0, 32'h40, 32'h0);
        send(4'h0, 32'h44, 32'h0);
        fork
            send(4'h0, 32'h48, 32'h0);
        join_none
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_rdy_low", req_rdy, 1'b0);
            chk("t4_hold_vld", rsp_vld, 1'b1);
            chk("t4_hold_rdata", rsp_rdata, 32'hDEADA5EF);
        end
        @(posedge clk); #1;
        rsp_rdy = 1'b1;
        @(negedge clk);
        chk("t4_rdy_before_pop", req_rdy, 1'b0);
        @(negedge clk);
        chk("t4_rdy_after_pop", req_rdy, 1'b1);
        wait fork;
        wait_got(base + 3, "t4_wait");
        chk("t4_order0", got[base].data, 32'hDEADA5EF);
        chk("t4_order1", got[base+1].data, 32'hC0DE0011);
        chk("t4_order2", got[base+2].data, 32'hC0DE0012);
        idle(2);

        // Out-of-range write leaves word 0 untouched
        base = got.size();
        send(4'hF, 32'h0000_1000, 32'hFFFFFFFF);
        send(4'h0, 32'h0, 32'h0);
        wait_got(base + 2, "t5_wait");
        chk("t5_oor_err", got[base].err, 1'b1);
        chk("t5_oor_rdata", got[base].data, 32'h0);
        chk("t5_word0", got[base+1].data, 32'hC0DE0000);
        chk("t5_word0_err", got[base+1].err, 1'b0);
        idle(3);

        // Streaming at full rate
        base = got.size();
        t0 = tick;
        for (int i = 0; i < 8; i++) send(4'h0, 32'(i * 4), 32'h0);
        chk("t6_accept_cycles", tick - t0, 8);
        wait_got(base + 8, "t6_wait");
        for (int k = 0; k < 8; k++) chk("t6_stream_data", got[base+k].data, 32'hC0DE0000 | 32'(k));
        for (int k = 1; k < 8; k++) chk("t6_consecutive", got[base+k].t - got[base+k-1].t, 1);
        idle(3);

        // Reset pulsed mid-burst
        base = got.size();
        for (int i = 0; i < 8; i++) begin
            req_vld = 1'b1; wen = 4'h0; addr = 32'(i * 4);
            @(posedge clk); #1;
            if (i == 3) begin
                rst_n = 1'b0;
                req_vld = 1'b0;
                break;
            end
        end
        n_at = got.size();
        chk("t6_pre_rst_count", n_at - base, 3);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_no_rsp_after_rst", got.size(), n_at);
        chk("t6_rdy_after_rst", req_rdy, 1'b1);
        @(posedge clk); #1;
        base = got.size();
        send(4'h0, 32'h14, 32'h0);
        wait_got(base + 1, "t6_persist_wait");
        chk("t6_persist", got[base].data, 32'hC0DE0005);
        idle(2);

        // Randomized traffic against the model, with one reset pulse
        for (int i = 0; i < 500; i++) begin
            req_vld = ($urandom % 10) < 7;
            wen     = ($urandom % 2) ? 4'h0 : 4'($urandom);
            addr    = 32'(($urandom % 20) * 4) | 32'($urandom % 4);
            if (($urandom % 12) == 0) addr = addr | (32'h1 << (12 + $urandom % 20));
            wdata   = $urandom;
            rsp_rdy = ($urandom % 10) < 7;
            if (i == 250) rst_n = 1'b0;
            if (i == 252) rst_n = 1'b1;
            @(posedge clk); #1;
        end
        req_vld = 1'b0;
        rsp_rdy = 1'b1;
        idle(6);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
